data_mem_ctrl: RTL and testbench

Byte-serial data memory controller that serves as the responder for the load store buffer's data-access port. It accepts one byte/half/word load or store at a time and sequences it over the single-byte RAM/IO bus. It returns load data sign- or zero-extended with a one-cycle completion pulse. It sits between the load store buffer and the memory arbiter, and handles the IO region (addr[17:16] == 2'b11) with io_buffer_full back-pressure.

---
 rtl/data_mem_ctrl_pkg.sv | 13 +
 rtl/data_mem_ctrl_load_extend.sv | 14 +
 rtl/data_mem_ctrl.sv | 99 +++++++++
 tb/tb_data_mem_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared width encodings, IO region decode and controller states
package data_mem_ctrl_pkg;
  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;
  localparam logic [1:0] IO_REGION = 2'b11;
  localparam int IO_HI = 17;
  localparam int IO_LO = 16;
  typedef enum logic [2:0] {IDLE, RD, RD_LAST, WR, DONE} state_t;
  function automatic logic [1:0] last_idx(input logic [1:0] w);
    return w == W_BYTE ? 2'd0 : w == W_HALF ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/data_mem_ctrl_load_extend.sv
// data_mem_ctrl_load_extend: sign/zero extension of byte, half and word load data
module data_mem_ctrl_load_extend
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  width,
  input  logic        sign_ext,
  output logic [31:0] ext
);
  // replicate the top loaded bit when signed, otherwise zero-fill
  always_comb
    ext = width == W_BYTE ? {{24{sign_ext & raw[7]}}, raw[7:0]} :
          width == W_HALF ? {{16{sign_ext & raw[15]}}, raw[15:0]} : raw;
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-serial load/store sequencer over a single-byte RAM/IO bus
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int IO_WRITE_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rw_en,
  input  logic              write_mode,
  input  logic [1:0]        width,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       value,
  output logic              idle,
  output logic              rw_feedback_en,
  output logic [31:0]       load_val,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  localparam int GW = IO_WRITE_GAP > 0 ? $clog2(IO_WRITE_GAP + 1) : 1;
  state_t            state;
  logic [ADDR_W-1:0] addr_q, a_cur, a_out;
  logic [31:0]       value_q, data_q, raw, ext;
  logic [1:0]        width_q, cnt, n_last, cap_idx;
  logic              sign_q, is_io, stall, issue, rd_hold, accept;
  logic [GW-1:0]     gap;

  data_mem_ctrl_load_extend u_ext (.raw(raw), .width(width_q), .sign_ext(sign_q), .ext(ext));

  // bus drive, stall decode and byte merge; while frozen mid-load the address of the byte
  // still awaiting capture is replayed so mem_din is valid again when rdy returns
  always_comb begin
    a_cur = addr_q + ADDR_W'(cnt);
    rd_hold = !rdy && ((state == RD && cnt != 2'd0) || state == RD_LAST);
    a_out = rd_hold && state == RD ? a_cur - ADDR_W'(1) : a_cur;
    is_io = a_cur[IO_HI:IO_LO] == IO_REGION;
    stall = is_io && (io_buffer_full || gap != '0);
    issue = state == WR && !stall;
    cap_idx = state == RD_LAST ? cnt : cnt - 2'd1;
    raw = data_q | ({24'b0, mem_din} << {cap_idx, 3'b000});
    accept = rw_en && (state == IDLE || state == DONE);
    idle = state == IDLE;
    rw_feedback_en = rdy && state == DONE;
    mem_wr = rdy && issue;
    mem_dout = state == WR ? value_q[{cnt, 3'b000} +: 8] : 8'h00;
    mem_a = (state == RD || state == WR || rd_hold) ? 32'(a_out) : 32'h0;
  end

  // request capture, byte sequencing and IO write spacing
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      value_q <= '0;
      data_q <= '0;
      width_q <= W_BYTE;
      sign_q <= 1'b0;
      cnt <= 2'd0;
      n_last <= 2'd0;
      gap <= '0;
      load_val <= '0;
    end else if (rdy) begin
      gap <= issue && is_io ? GW'(IO_WRITE_GAP) : gap != '0 ? gap - GW'(1) : gap;
      if (accept) begin
        state <= write_mode ? WR : RD;
        addr_q <= addr;
        value_q <= value;
        width_q <= width;
        sign_q <= sign_ext;
        n_last <= last_idx(width);
        cnt <= 2'd0;
        data_q <= '0;
      end else begin
        case (state)
          RD: begin
            if (cnt != 2'd0) data_q <= raw;
            if (cnt == n_last) state <= RD_LAST;
            else cnt <= cnt + 2'd1;
          end
          RD_LAST: begin
            load_val <= ext;
            state <= DONE;
          end
          WR: if (issue) begin
            if (cnt == n_last) state <= DONE;
            else cnt <= cnt + 2'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for the byte-serial data memory controller
module tb_data_mem_ctrl;
  localparam int GAP = 1;
  logic clk = 0, rst = 1, rdy = 1, rw_en = 0, write_mode = 0, sign_ext = 0, io_buffer_full = 0;
  logic [1:0] width = 0;
  logic [17:0] addr = 0;
  logic [31:0] value = 0;
  logic idle, rw_feedback_en, mem_wr;
  logic [31:0] load_val, mem_a;
  logic [7:0] mem_din = 0, mem_dout;
  logic [7:0] ram [0:262143];
  logic [31:0] alog [0:1023];
  typedef struct {int cyc; logic ld; logic [31:0] val;} fb_t;
  typedef struct {int cyc; logic [17:0] a; logic [7:0] d;} wr_t;
  fb_t fq[$];
  wr_t wq[$];
  fb_t e;
  wr_t w;
  int cyc = 0, total = 0, bad = 0, last_io = -100, fs = -1, fe = -1, a0 = 0;

  data_mem_ctrl #(.ADDR_W(18), .IO_WRITE_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rw_en(rw_en), .write_mode(write_mode), .width(width),
    .sign_ext(sign_ext), .addr(addr), .value(value), .idle(idle), .rw_feedback_en(rw_feedback_en),
    .load_val(load_val), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM with one-cycle registered read
  always @(posedge clk) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [31:0] r, input logic [1:0] wd, input logic s);
    if (wd == 2'd0) return s && r[7] ? {24'hFFFFFF, r[7:0]} : {24'h0, r[7:0]};
    if (wd == 2'd1) return s && r[15] ? {16'hFFFF, r[15:0]} : {16'h0, r[15:0]};
    return r;
  endfunction

  // drive one request in the current cycle and push its expected outcome
  task automatic req(input logic wm, input logic [1:0] wd, input logic se, input logic [17:0] a,
                     input logic [31:0] v, input int extra);
    int n;
    int t;
    logic [31:0] raw;
    logic [17:0] b;
    n = wd == 2'd0 ? 1 : wd == 2'd1 ? 2 : 4;
    raw = 0;
    rw_en = 1; write_mode = wm; width = wd; sign_ext = se; addr = a; value = v; a0 = cyc;
    if (!wm) begin
      for (int i = 0; i < n; i++) begin
        b = a + 18'(i);
        raw[8*i +: 8] = ram[b];
      end
      fq.push_back('{cyc + n + 2 + extra, 1'b1, ext_model(raw, wd, se)});
    end else begin
      t = cyc + 1;
      for (int i = 0; i < n; i++) begin
        b = a + 18'(i);
        if (b[17:16] == 2'b11)
          while (t < last_io + GAP + 1 || (t >= fs && t <= fe)) t++;
        wq.push_back('{t, b, v[8*i +: 8]});
        if (b[17:16] == 2'b11) last_io = t;
        t++;
      end
      fq.push_back('{t, 1'b0, 32'h0});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic wm, input logic [1:0] wd, input logic se, input logic [17:0] a,
                    input logic [31:0] v, input int extra);
    req(wm, wd, se, a, v, extra);
    step();
    rw_en = 0;
  endtask

  task automatic wait_fb();
    int k = 0;
    while (!rw_feedback_en && k < 60) begin
      step();
      k++;
    end
    chk("fb_timeout", {31'b0, rw_feedback_en}, 32'd1);
  endtask

  // output monitor: pops the scoreboard on every completion pulse and write strobe
  always @(negedge clk) begin
    if (cyc < 1024) alog[cyc] = mem_a;
    if (rw_feedback_en) begin
      if (fq.size() == 0) chk("fb_unexpected", {31'b0, rw_feedback_en}, 32'd0);
      else begin
        e = fq.pop_front();
        chk("fb_cycle", 32'(cyc), 32'(e.cyc));
        chk("idle_in_fb", {31'b0, idle}, 32'd0);
        if (e.ld) chk("load_val", load_val, e.val);
      end
    end
    if (mem_wr) begin
      if (mem_a[17:16] == 2'b11) chk("io_full_wr", {31'b0, io_buffer_full}, 32'd0);
      if (wq.size() == 0) chk("wr_unexpected", {31'b0, mem_wr}, 32'd0);
      else begin
        w = wq.pop_front();
        chk("wr_addr", mem_a, {14'b0, w.a});
        chk("wr_data", {24'b0, mem_dout}, {24'b0, w.d});
        chk("wr_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a_w, a_b, a_r;
    ram[18'h100] = 8'h78; ram[18'h101] = 8'h56; ram[18'h102] = 8'h34; ram[18'h103] = 8'h12;
    ram[18'h005] = 8'h80; ram[18'h010] = 8'h01; ram[18'h011] = 8'h80;
    repeat (3) step();
    chk("rst_idle", {31'b0, idle}, 32'd1);
    chk("rst_fb", {31'b0, rw_feedback_en}, 32'd0);
    chk("rst_load_val", load_val, 32'd0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_mem_dout", {24'b0, mem_dout}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    rst = 0;
    step();
    go(0, 2'd2, 0, 18'h100, 0, 0);
    a_w = a0;
    wait_fb(); step();
    for (int i = 0; i < 4; i++) chk("ld_addr", alog[a_w + 1 + i], 32'h100 + 32'(i));
    chk("ld_tail_addr", alog[a_w + 5], 32'h0);
    go(0, 2'd0, 1, 18'h005, 0, 0);
    wait_fb();
    req(0, 2'd0, 0, 18'h005, 0, 0);
    a_b = a0;
    step(); rw_en = 0;
    wait_fb(); step();
    chk("b2b_addr", alog[a_b + 1], 32'h5);
    go(0, 2'd1, 1, 18'h010, 0, 0);
    wait_fb(); step();
    go(0, 2'd1, 0, 18'h101, 0, 0);
    wait_fb(); step();
    go(1, 2'd2, 0, 18'h3FFFE, 32'hDEADBEEF, 0);
    wait_fb(); step();
    go(0, 2'd1, 0, 18'h0, 0, 0);
    wait_fb(); step();
    io_buffer_full = 1; fs = cyc + 1; fe = cyc + 3;
    go(1, 2'd0, 0, 18'h30000, 32'hA5, 0);
    step(); step(); step();
    io_buffer_full = 0;
    wait_fb();
    req(1, 2'd1, 0, 18'h30001, 32'hC3B2, 0);
    step(); rw_en = 0;
    wait_fb(); step();
    go(0, 2'd2, 0, 18'h100, 0, 2);
    step(); rdy = 0;
    step(); step(); rdy = 1;
    wait_fb(); step();
    a_r = cyc;
    rw_en = 1; write_mode = 1; width = 2'd2; addr = 18'h200; value = 32'h11223344;
    wq.push_back('{a_r + 1, 18'h200, 8'h44});
    wq.push_back('{a_r + 2, 18'h201, 8'h33});
    step(); rw_en = 0;
    step(); rst = 1;
    step(); rst = 0;
    chk("rst_mid_idle", {31'b0, idle}, 32'd1);
    chk("rst_mid_wr", {31'b0, mem_wr}, 32'd0);
    repeat (8) step();
    go(0, 2'd1, 0, 18'h100, 0, 0);
    wait_fb(); step();
    repeat (2) step();
    chk("fb_left", 32'(fq.size()), 32'd0);
    chk("wr_left", 32'(wq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
